// File: rtl/fpu_seq_pkg.sv
// Shared types and width helpers for the FPU request-buffer memory sequencer.
// Imported by the address walker and the sequencer top.
package fpu_seq_pkg;

    localparam int WORD_BYTES = 8;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } fill_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_READ = 2'd1,
        D_LAST = 2'd2,
        D_SEND = 2'd3
    } drain_state_t;

    function automatic int baddr_bits(input int depth);
        return $clog2(depth);
    endfunction

    // A single column still needs one address bit so the port never collapses to zero width.
    function automatic int caddr_bits(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int waddr_bits(input int cols);
        return caddr_bits(cols - 2);
    endfunction

endpackage

// File: rtl/fpu_addr_walker.sv
// Column/byte-address counter stepping one 64-bit word at a time.
// The byte address wraps at the end of a column and the column wraps at the end of the bank.
module fpu_addr_walker #(
    parameter int DEPTH = 512,
    parameter int COLS  = 10,
    parameter int ABITS = 9,
    parameter int CBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [ABITS-1:0] addr,
    output logic [CBITS-1:0] col,
    output logic             last
);
    import fpu_seq_pkg::*;

    localparam logic [ABITS-1:0] ADDR_END  = ABITS'(DEPTH - WORD_BYTES);
    localparam logic [ABITS-1:0] ADDR_STEP = ABITS'(WORD_BYTES);
    localparam logic [CBITS-1:0] COL_END   = CBITS'(COLS - 1);

    logic [ABITS-1:0] addr_r;
    logic [CBITS-1:0] col_r;

    // Advance the word position on each step, wrapping byte address then column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= '0;
            col_r  <= '0;
        end else if (step) begin
            if (addr_r == ADDR_END) begin
                addr_r <= '0;
                col_r  <= (col_r == COL_END) ? '0 : col_r + CBITS'(1);
            end else begin
                addr_r <= addr_r + ADDR_STEP;
            end
        end
    end

    assign addr = addr_r;
    assign col  = col_r;
    assign last = (addr_r == ADDR_END) && (col_r == COL_END);

endmodule

// File: rtl/fpu_request_sequencer.sv
// Memory-side sequencer: fills the idle read bank from the memory read channel and
// drains the finished write bank byte by byte into packed 64-bit memory writes.
module fpu_request_sequencer
    import fpu_seq_pkg::*;
#(
    parameter  int BUFFER_DEPTH = 512,
    parameter  int COL_WIDTH    = 10,
    localparam int BADDR_BITS   = baddr_bits(BUFFER_DEPTH),
    localparam int CADDR_BITS   = caddr_bits(COL_WIDTH),
    localparam int WADDR_BITS   = waddr_bits(COL_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fill_start,
    input  logic                             drain_start,
    input  logic [63:0]                      mem_rdata,
    input  logic                             mem_rvalid,
    output logic                             mem_rready,
    output logic [63:0]                      mem_wdata,
    output logic                             mem_wvalid,
    input  logic                             mem_wready,
    output logic [BADDR_BITS+CADDR_BITS-1:0] request_write_address,
    output logic                             wr_en_rd_buffer,
    output logic                             rd_buffer_sel,
    output logic [BADDR_BITS+WADDR_BITS-1:0] request_read_address,
    input  logic [7:0]                       request_data_out,
    output logic                             wr_buffer_sel,
    output logic                             fill_busy,
    output logic                             drain_busy,
    output logic                             fill_done,
    output logic                             drain_done
);

    localparam int RADDR_BITS = BADDR_BITS + WADDR_BITS;

    fill_state_t                        fill_state_r;
    logic                               mem_rready_r;
    logic                               wr_en_r;
    logic [BADDR_BITS+CADDR_BITS-1:0]   wr_addr_r;
    logic                               rd_sel_r;
    logic                               fill_busy_r;
    logic                               fill_done_r;
    logic                               fill_last_r;

    drain_state_t                       drain_state_r;
    logic [2:0]                         byte_k_r;
    logic [RADDR_BITS-1:0]              rd_addr_r;
    logic [63:0]                        pack_r;
    logic                               mem_wvalid_r;
    logic                               wr_sel_r;
    logic                               drain_busy_r;
    logic                               drain_done_r;
    logic                               drain_last_r;

    logic                               fill_accept_s;
    logic [BADDR_BITS-1:0]              fill_addr_s;
    logic [CADDR_BITS-1:0]              fill_col_s;
    logic                               fill_walk_last_s;
    logic                               drain_step_s;
    logic [BADDR_BITS-1:0]              drain_addr_s;
    logic [WADDR_BITS-1:0]              drain_col_s;
    logic                               drain_walk_last_s;

    assign fill_accept_s = (fill_state_r == F_RUN) && mem_rready_r && mem_rvalid;
    assign drain_step_s  = (drain_state_r == D_READ) && (byte_k_r == 3'd7);

    fpu_addr_walker #(
        .DEPTH (BUFFER_DEPTH),
        .COLS  (COL_WIDTH),
        .ABITS (BADDR_BITS),
        .CBITS (CADDR_BITS)
    ) u_fill_walker (
        .clk  (clk),
        .rst  (rst),
        .step (fill_accept_s),
        .addr (fill_addr_s),
        .col  (fill_col_s),
        .last (fill_walk_last_s)
    );

    fpu_addr_walker #(
        .DEPTH (BUFFER_DEPTH),
        .COLS  (COL_WIDTH - 2),
        .ABITS (BADDR_BITS),
        .CBITS (WADDR_BITS)
    ) u_drain_walker (
        .clk  (clk),
        .rst  (rst),
        .step (drain_step_s),
        .addr (drain_addr_s),
        .col  (drain_col_s),
        .last (drain_walk_last_s)
    );

    // Fill engine: accept words, issue one bank write per word, flip the read bank when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_state_r <= F_IDLE;
            mem_rready_r <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            rd_sel_r     <= 1'b0;
            fill_busy_r  <= 1'b0;
            fill_done_r  <= 1'b0;
            fill_last_r  <= 1'b0;
        end else begin
            wr_en_r     <= 1'b0;
            fill_done_r <= 1'b0;
            case (fill_state_r)
                F_IDLE: begin
                    if (fill_start) begin
                        fill_state_r <= F_RUN;
                        mem_rready_r <= 1'b1;
                        fill_busy_r  <= 1'b1;
                    end
                end
                F_RUN: begin
                    if (fill_last_r) begin
                        fill_state_r <= F_IDLE;
                        fill_busy_r  <= 1'b0;
                        fill_done_r  <= 1'b1;
                        rd_sel_r     <= ~rd_sel_r;
                        fill_last_r  <= 1'b0;
                    end else if (fill_accept_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= {fill_col_s, fill_addr_s};
                        // Stop accepting as soon as the final word is in hand.
                        if (fill_walk_last_s) begin
                            fill_last_r  <= 1'b1;
                            mem_rready_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    fill_state_r <= F_IDLE;
                    mem_rready_r <= 1'b0;
                    fill_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Drain engine: read 8 bytes, pack them little-endian, hold the word until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_state_r <= D_IDLE;
            byte_k_r      <= 3'd0;
            rd_addr_r     <= '0;
            pack_r        <= 64'd0;
            mem_wvalid_r  <= 1'b0;
            wr_sel_r      <= 1'b0;
            drain_busy_r  <= 1'b0;
            drain_done_r  <= 1'b0;
            drain_last_r  <= 1'b0;
        end else begin
            drain_done_r <= 1'b0;
            case (drain_state_r)
                D_IDLE: begin
                    if (drain_start) begin
                        drain_state_r <= D_READ;
                        wr_sel_r      <= ~wr_sel_r;
                        drain_busy_r  <= 1'b1;
                        byte_k_r      <= 3'd0;
                        rd_addr_r     <= {drain_col_s, drain_addr_s};
                    end
                end
                D_READ: begin
                    // Byte data lags its address by one cycle, so nothing arrives on lane 0's issue cycle.
                    if (byte_k_r != 3'd0) begin
                        pack_r <= {request_data_out, pack_r[63:8]};
                    end
                    if (byte_k_r == 3'd7) begin
                        drain_state_r <= D_LAST;
                        drain_last_r  <= drain_walk_last_s;
                    end else begin
                        byte_k_r  <= byte_k_r + 3'd1;
                        rd_addr_r <= {rd_addr_r[RADDR_BITS-1:3], byte_k_r + 3'd1};
                    end
                end
                D_LAST: begin
                    pack_r        <= {request_data_out, pack_r[63:8]};
                    mem_wvalid_r  <= 1'b1;
                    drain_state_r <= D_SEND;
                end
                D_SEND: begin
                    if (mem_wready) begin
                        mem_wvalid_r <= 1'b0;
                        if (drain_last_r) begin
                            drain_state_r <= D_IDLE;
                            drain_busy_r  <= 1'b0;
                            drain_done_r  <= 1'b1;
                            drain_last_r  <= 1'b0;
                        end else begin
                            drain_state_r <= D_READ;
                            byte_k_r      <= 3'd0;
                            rd_addr_r     <= {drain_col_s, drain_addr_s};
                        end
                    end
                end
                default: begin
                    drain_state_r <= D_IDLE;
                    mem_wvalid_r  <= 1'b0;
                    drain_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rready            = mem_rready_r;
    assign mem_wdata             = pack_r;
    assign mem_wvalid            = mem_wvalid_r;
    assign request_write_address = wr_addr_r;
    assign wr_en_rd_buffer       = wr_en_r;
    assign rd_buffer_sel         = rd_sel_r;
    assign request_read_address  = rd_addr_r;
    assign wr_buffer_sel         = wr_sel_r;
    assign fill_busy             = fill_busy_r;
    assign drain_busy            = drain_busy_r;
    assign fill_done             = fill_done_r;
    assign drain_done            = drain_done_r;

endmodule

// File: tb/tb_fpu_request_sequencer.sv
// Self-checking bench for fpu_request_sequencer with a 16-byte x 4-column buffer:
// 8 fill words and 4 drain words per run, checked against address/packing arithmetic.
module tb_fpu_request_sequencer;

    localparam int DEPTH = 16;
    localparam int COLS  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fill_start = 1'b0;
    logic        drain_start = 1'b0;
    logic [63:0] mem_rdata = 64'd0;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready;
    logic [63:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready = 1'b0;
    logic [5:0]  request_write_address;
    logic        wr_en_rd_buffer;
    logic        rd_buffer_sel;
    logic [4:0]  request_read_address;
    logic [7:0]  request_data_out;
    logic        wr_buffer_sel;
    logic        fill_busy;
    logic        drain_busy;
    logic        fill_done;
    logic        drain_done;

    always #5 clk = ~clk;

    fpu_request_sequencer #(
        .BUFFER_DEPTH (DEPTH),
        .COL_WIDTH    (COLS)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .fill_start            (fill_start),
        .drain_start           (drain_start),
        .mem_rdata             (mem_rdata),
        .mem_rvalid            (mem_rvalid),
        .mem_rready            (mem_rready),
        .mem_wdata             (mem_wdata),
        .mem_wvalid            (mem_wvalid),
        .mem_wready            (mem_wready),
        .request_write_address (request_write_address),
        .wr_en_rd_buffer       (wr_en_rd_buffer),
        .rd_buffer_sel         (rd_buffer_sel),
        .request_read_address  (request_read_address),
        .request_data_out      (request_data_out),
        .wr_buffer_sel         (wr_buffer_sel),
        .fill_busy             (fill_busy),
        .drain_busy            (drain_busy),
        .fill_done             (fill_done),
        .drain_done            (drain_done)
    );

    // Write-bank model: flat byte image, address {col,byte} is simply col*16+byte.
    logic [7:0] wbank [0:31];
    always @(posedge clk) request_data_out <= wbank[request_read_address];

    logic [83:0] outs_s;
    assign outs_s = {mem_rready, mem_wdata, mem_wvalid, request_write_address, wr_en_rd_buffer,
                     rd_buffer_sel, request_read_address, wr_buffer_sel, fill_busy, drain_busy,
                     fill_done, drain_done};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wr_q[$];
    int          wr_cyc_q[$];
    int          fd_cyc_q[$];
    int          dd_cyc_q[$];
    int          hs_cyc_q[$];
    logic [63:0] hs_q[$];

    always @(negedge clk) begin
        if (wr_en_rd_buffer) begin
            wr_q.push_back(int'(request_write_address));
            wr_cyc_q.push_back(cyc);
        end
        if (fill_done) fd_cyc_q.push_back(cyc);
        if (drain_done) dd_cyc_q.push_back(cyc);
        if (mem_wvalid && mem_wready) begin
            hs_q.push_back(mem_wdata);
            hs_cyc_q.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        wr_cyc_q.delete();
        fd_cyc_q.delete();
        dd_cyc_q.delete();
        hs_cyc_q.delete();
        hs_q.delete();
    endtask

    // Expected drain word w: bytes at flat addresses w*8 .. w*8+7, byte k in lane k.
    function automatic logic [63:0] exp_word(input int w);
        logic [63:0] r;
        r = 64'd0;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = wbank[w*8 + k];
        return r;
    endfunction

    // Fill word n lands at column n/2, byte (n%2)*8, i.e. flat value n*8.
    task automatic check_fill_seq(input string tag);
        check({tag, "_nwrites"}, wr_q.size(), 8);
        for (int n = 0; n < wr_q.size() && n < 8; n++)
            check({tag, "_waddr"}, wr_q[n], (n / 2) * 16 + (n % 2) * 8);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_nwords"}, hs_q.size(), 4);
        for (int w = 0; w < hs_q.size() && w < 4; w++)
            check({tag, "_word"}, hs_q[w], exp_word(w));
    endtask

    task automatic randomize_bank();
        for (int i = 0; i < 32; i++) wbank[i] = 8'($urandom);
    endtask

    int          s_cyc;
    int          busy_drops;
    int          unstable;
    logic [63:0] held_data;
    logic [4:0]  held_addr;

    initial begin
        for (int i = 0; i < 32; i++) wbank[i] = 8'(i);

        // Reset state
        repeat (3) tick();
        check("reset_outputs", outs_s, 0);
        rst = 1'b0;
        tick();
        check("reset_sels", {rd_buffer_sel, wr_buffer_sel}, 0);

        // Fill with continuous valid
        clear_mon();
        fill_start = 1'b1;
        mem_rvalid = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 40 && fd_cyc_q.size() == 0; i++) begin
            mem_rdata = {$urandom, $urandom};
            tick();
        end
        mem_rvalid = 1'b0;
        repeat (3) tick();
        check_fill_seq("t1");
        check("t1_done_count", fd_cyc_q.size(), 1);
        if (fd_cyc_q.size() > 0 && wr_cyc_q.size() == 8) begin
            check("t1_done_lat", fd_cyc_q[0] - wr_cyc_q[7], 1);
            check("t1_burst_len", wr_cyc_q[7] - wr_cyc_q[0], 7);
        end
        check("t1_rd_sel", rd_buffer_sel, 1);
        check("t1_idle", {fill_busy, mem_rready}, 0);

        // Fill with rvalid toggling every other cycle
        clear_mon();
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        busy_drops = 0;
        for (int i = 0; i < 60 && fd_cyc_q.size() == 0; i++) begin
            mem_rvalid = ~mem_rvalid;
            mem_rdata  = {$urandom, $urandom};
            tick();
            if (fd_cyc_q.size() == 0 && !fill_busy && !fill_done) busy_drops++;
        end
        mem_rvalid = 1'b0;
        repeat (3) tick();
        check_fill_seq("t2");
        check("t2_busy_held", busy_drops, 0);
        check("t2_done_count", fd_cyc_q.size(), 1);
        check("t2_rd_sel", rd_buffer_sel, 0);

        // Drain with byte = address, immediate wready
        clear_mon();
        mem_wready  = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        s_cyc = cyc;
        check("t3_wr_sel", wr_buffer_sel, 1);
        check("t3_busy", drain_busy, 1);
        for (int i = 0; i < 100 && dd_cyc_q.size() == 0; i++) tick();
        repeat (2) tick();
        check_words("t3");
        if (hs_q.size() > 0) begin
            check("t3_first_word", hs_q[0], 64'h0706050403020100);
            check("t3_first_lat", hs_cyc_q[0] - s_cyc, 9);
        end
        for (int w = 1; w < hs_cyc_q.size(); w++)
            check("t3_word_spacing", hs_cyc_q[w] - hs_cyc_q[w-1], 10);
        check("t3_done_count", dd_cyc_q.size(), 1);
        if (dd_cyc_q.size() > 0 && hs_cyc_q.size() == 4)
            check("t3_done_lat", dd_cyc_q[0] - hs_cyc_q[3], 1);
        check("t3_idle", {drain_busy, mem_wvalid}, 0);

        // Drain with 20 cycles of backpressure on the first word
        randomize_bank();
        clear_mon();
        mem_wready  = 1'b0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        check("t4_wr_sel", wr_buffer_sel, 0);
        for (int i = 0; i < 20 && !mem_wvalid; i++) tick();
        check("t4_wvalid", mem_wvalid, 1);
        held_data = mem_wdata;
        held_addr = request_read_address;
        unstable  = 0;
        repeat (20) begin
            tick();
            if (mem_wvalid !== 1'b1 || mem_wdata !== held_data || request_read_address !== held_addr)
                unstable++;
        end
        check("t4_stable", unstable, 0);
        check("t4_held_word", held_data, exp_word(0));
        check("t4_held_addr", held_addr, 7);
        check("t4_no_early_hs", hs_q.size(), 0);
        mem_wready = 1'b1;
        for (int i = 0; i < 100 && dd_cyc_q.size() == 0; i++) tick();
        repeat (2) tick();
        check_words("t4");
        check("t4_done_count", dd_cyc_q.size(), 1);

        // Simultaneous fill and drain, with extra starts while busy
        randomize_bank();
        clear_mon();
        fill_start  = 1'b1;
        drain_start = 1'b1;
        mem_wready  = 1'b0;
        tick();
        for (int i = 0; i < 400 && (fd_cyc_q.size() == 0 || dd_cyc_q.size() == 0); i++) begin
            fill_start  = fill_busy && (i % 5 == 3);
            drain_start = drain_busy && (i % 7 == 2);
            mem_rvalid  = 1'($urandom_range(0, 1));
            mem_wready  = 1'($urandom_range(0, 1));
            mem_rdata   = {$urandom, $urandom};
            tick();
        end
        fill_start  = 1'b0;
        drain_start = 1'b0;
        mem_rvalid  = 1'b0;
        mem_wready  = 1'b1;
        repeat (4) tick();
        check_fill_seq("t5");
        check_words("t5");
        check("t5_fill_done_count", fd_cyc_q.size(), 1);
        check("t5_drain_done_count", dd_cyc_q.size(), 1);
        check("t5_sels", {rd_buffer_sel, wr_buffer_sel}, 2'b11);
        check("t5_idle", {fill_busy, drain_busy}, 0);

        // Reset in the middle of both transfers
        clear_mon();
        fill_start  = 1'b1;
        drain_start = 1'b1;
        mem_rvalid  = 1'b1;
        tick();
        fill_start  = 1'b0;
        drain_start = 1'b0;
        repeat (5) tick();
        check("t6_busy_before", {fill_busy, drain_busy, wr_en_rd_buffer}, 3'b111);
        rst = 1'b1;
        #1;
        check("t6_reset_outputs", outs_s, 0);
        check("t6_reset_sels", {rd_buffer_sel, wr_buffer_sel}, 0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("t6_no_fill_done", fd_cyc_q.size(), 0);
        check("t6_no_drain_done", dd_cyc_q.size(), 0);
        clear_mon();
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 40 && fd_cyc_q.size() == 0; i++) tick();
        mem_rvalid = 1'b0;
        repeat (3) tick();
        check_fill_seq("t6");
        check("t6_done_count", fd_cyc_q.size(), 1);
        check("t6_rd_sel", rd_buffer_sel, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
